// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// FSM states, opcode/funct values, ALU op codes and datapath mux selects.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXEC,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control-unit bundle: IR fields and Zero flag in, datapath strobes/selects out.
// master = control unit, slave = datapath side.
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_en;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero,
        output alu_control, alu_src_a, alu_src_b, pc_src, iord, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, pc_en, illegal_op
    );

    modport slave (
        output opcode, funct, zero,
        input  alu_control, alu_src_a, alu_src_b, pc_src, iord, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, pc_en, illegal_op
    );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct to ALU op decode; unknown funct falls back to ADD and flags it.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       illegal_funct
);

    always_comb begin
        alu_control   = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            FN_NOR:  alu_control = ALU_NOR;
            default: illegal_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS Moore control FSM driving datapath selects and ALU op.
// Build option MC_CTRL_BNE_EN adds bne (opcode 000101) through the BRANCH state.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mips_mc_control_if.master bus
);

    state_t     state_q, state_d;

    logic [3:0] dec_alu_control;
    logic       dec_illegal_funct;

    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       branch;
    logic       illegal_op;
    logic       branch_taken;

    alu_decoder u_alu_decoder (
        .funct         (bus.funct),
        .alu_control   (dec_alu_control),
        .illegal_funct (dec_illegal_funct)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        alu_control = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REGB;
        pc_src      = PCSRC_ALU;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut while the opcode resolves
                alu_src_b = SRCB_IMM_SH2;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = dec_alu_control;
                illegal_op  = dec_illegal_funct;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = PCSRC_ALUOUT;
                branch      = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifdef MC_CTRL_BNE_EN
    // The IR still holds the opcode in BRANCH, so it picks the Zero polarity
    assign branch_taken = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
    assign branch_taken = bus.zero;
`endif

    // Everything is held at zero while reset is asserted, including alu_control
    assign bus.alu_control = rst_n ? alu_control : 4'b0000;
    assign bus.alu_src_a   = rst_n & alu_src_a;
    assign bus.alu_src_b   = rst_n ? alu_src_b : 2'b00;
    assign bus.pc_src      = rst_n ? pc_src : 2'b00;
    assign bus.iord        = rst_n & iord;
    assign bus.mem_write   = rst_n & mem_write;
    assign bus.ir_write    = rst_n & ir_write;
    assign bus.reg_dst     = rst_n & reg_dst;
    assign bus.mem_to_reg  = rst_n & mem_to_reg;
    assign bus.reg_write   = rst_n & reg_write;
    assign bus.pc_en       = rst_n & (pc_write | (branch & branch_taken));
    assign bus.illegal_op  = rst_n & illegal_op;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: per-cycle expected output vectors are
// queued as stimulus is driven and compared against sampled DUT outputs.
module tb_mips_mc_control;

    localparam int ST_F  = 0;
    localparam int ST_D  = 1;
    localparam int ST_MA = 2;
    localparam int ST_MR = 3;
    localparam int ST_MB = 4;
    localparam int ST_MW = 5;
    localparam int ST_EX = 6;
    localparam int ST_AW = 7;
    localparam int ST_BR = 8;
    localparam int ST_AE = 9;
    localparam int ST_AB = 10;
    localparam int ST_J  = 11;

    logic clk;
    logic rst_n;

    mips_mc_control_if bus ();

    mips_mc_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    int          errors;
    int          checks;

    function automatic logic opcode_legal(input logic [5:0] opc);
        logic ok;
        ok = (opc == 6'b100011) || (opc == 6'b101011) || (opc == 6'b000000) ||
             (opc == 6'b000100) || (opc == 6'b001000) || (opc == 6'b000010);
`ifdef MC_CTRL_BNE_EN
        if (opc == 6'b000101) ok = 1'b1;
`endif
        return ok;
    endfunction

    function automatic logic [4:0] funct_alu(input logic [5:0] fn);
        // {illegal, alu_control}
        case (fn)
            6'b100000: return {1'b0, 4'b0010};
            6'b100010: return {1'b0, 4'b0110};
            6'b100100: return {1'b0, 4'b0000};
            6'b100101: return {1'b0, 4'b0001};
            6'b101010: return {1'b0, 4'b0111};
            6'b100111: return {1'b0, 4'b1100};
            default:   return {1'b1, 4'b0010};
        endcase
    endfunction

    function automatic logic [16:0] exp_vec(input int stage, input logic [5:0] opc,
                                            input logic [5:0] fn, input logic z);
        logic [3:0] alu;
        logic       sa, iord, mw, irw, rd, mtr, rw, pce, ill;
        logic [1:0] sb, ps;
        logic [4:0] fa;
        alu = 4'b0010; sa = 0; sb = 2'b00; ps = 2'b00;
        iord = 0; mw = 0; irw = 0; rd = 0; mtr = 0; rw = 0; pce = 0; ill = 0;
        fa = funct_alu(fn);
        case (stage)
            ST_F:  begin sb = 2'b01; irw = 1; pce = 1; end
            ST_D:  begin sb = 2'b11; ill = ~opcode_legal(opc); end
            ST_MA: begin sa = 1; sb = 2'b10; end
            ST_MR: iord = 1;
            ST_MB: begin mtr = 1; rw = 1; end
            ST_MW: begin iord = 1; mw = 1; end
            ST_EX: begin sa = 1; alu = fa[3:0]; ill = fa[4]; end
            ST_AW: begin rd = 1; rw = 1; end
            ST_BR: begin
                alu = 4'b0110; sa = 1; ps = 2'b01;
                pce = (opc == 6'b000101) ? ~z : z;
            end
            ST_AE: begin sa = 1; sb = 2'b10; end
            ST_AB: rw = 1;
            ST_J:  begin ps = 2'b10; pce = 1; end
            default: ;
        endcase
        return {alu, sa, sb, ps, iord, mw, irw, rd, mtr, rw, pce, ill};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
                bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
                bus.mem_to_reg, bus.reg_write, bus.pc_en, bus.illegal_op};
    endfunction

    // One state's worth of stimulus; zero is inverted during FETCH to prove it is ignored
    task automatic drive_cycle(input int stage, input logic [5:0] opc,
                               input logic [5:0] fn, input logic z);
        @(negedge clk);
        bus.opcode = opc;
        bus.funct  = fn;
        bus.zero   = (stage == ST_F) ? ~z : z;
        exp_q.push_back(exp_vec(stage, opc, fn, z));
        #1;
        obs_q.push_back(dut_vec());
    endtask

    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input logic z);
        drive_cycle(ST_F, opc, fn, z);
        drive_cycle(ST_D, opc, fn, z);
        if (!opcode_legal(opc)) return;
        case (opc)
            6'b100011: begin
                drive_cycle(ST_MA, opc, fn, z);
                drive_cycle(ST_MR, opc, fn, z);
                drive_cycle(ST_MB, opc, fn, z);
            end
            6'b101011: begin
                drive_cycle(ST_MA, opc, fn, z);
                drive_cycle(ST_MW, opc, fn, z);
            end
            6'b000000: begin
                drive_cycle(ST_EX, opc, fn, z);
                drive_cycle(ST_AW, opc, fn, z);
            end
            6'b001000: begin
                drive_cycle(ST_AE, opc, fn, z);
                drive_cycle(ST_AB, opc, fn, z);
            end
            6'b000010: drive_cycle(ST_J, opc, fn, z);
            default:   drive_cycle(ST_BR, opc, fn, z);
        endcase
    endtask

    task automatic test_reset();
        logic [16:0] e, o;
        int cyc;
        bus.opcode = 6'b100011; bus.funct = 6'b0; bus.zero = 1'b1;
        rst_n = 1'b0;
        #3;
        exp_q.push_back(17'h0);
        obs_q.push_back(dut_vec());
        @(posedge clk); #1 rst_n = 1'b1;
        // lw started, then reset while in MEMRD
        drive_cycle(ST_F, 6'b100011, 6'b0, 1'b1);
        drive_cycle(ST_D, 6'b100011, 6'b0, 1'b1);
        drive_cycle(ST_MA, 6'b100011, 6'b0, 1'b1);
        drive_cycle(ST_MR, 6'b100011, 6'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        exp_q.push_back(17'h0);
        obs_q.push_back(dut_vec());
        @(posedge clk); #1;
        exp_q.push_back(17'h0);
        obs_q.push_back(dut_vec());
        rst_n = 1'b1;
        run_instr(6'b100011, 6'b0, 1'b1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_lw cycle %0d: got %h want %h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_mem();
        logic [16:0] e, o;
        int cyc;
        run_instr(6'b100011, 6'b101010, 1'b0);
        run_instr(6'b101011, 6'b000000, 1'b1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mem_lw_sw cycle %0d: got %h want %h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_rtype();
        logic [16:0] e, o;
        logic [5:0] fns [8];
        int cyc;
        fns = '{6'b100010, 6'b100111, 6'b000000, 6'b100000,
                6'b100100, 6'b100101, 6'b101010, 6'b111111};
        for (int i = 0; i < 8; i++) run_instr(6'b000000, fns[i], i[0]);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rtype cycle %0d: got %h want %h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_branch_jump();
        logic [16:0] e, o;
        int cyc;
        run_instr(6'b000100, 6'b0, 1'b1);
        run_instr(6'b000100, 6'b0, 1'b0);
        run_instr(6'b001000, 6'b0, 1'b1);
        run_instr(6'b000010, 6'b0, 1'b1);
        run_instr(6'b000010, 6'b0, 1'b0);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch_addi_jump cycle %0d: got %h want %h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_illegal_and_bne();
        logic [16:0] e, o;
        int cyc;
        run_instr(6'b111111, 6'b0, 1'b1);
        run_instr(6'b000101, 6'b0, 1'b0);
        run_instr(6'b000101, 6'b0, 1'b1);
        run_instr(6'b000000, 6'b100000, 1'b1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL illegal_bne cycle %0d: got %h want %h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e, o;
        logic [5:0] ops [6];
        int cyc;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        for (int i = 0; i < 30; i++)
            run_instr(ops[$urandom_range(0, 5)], 6'($urandom_range(0, 63)),
                      1'($urandom_range(0, 1)));
        cyc = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", cyc, o, e);
            end
            cyc++;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mem();
        test_rtype();
        test_branch_jump();
        test_illegal_and_bne();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle MIPS control unit: a Moore FSM that sequences fetch/decode/execute/memory/writeback and drives the datapath selects and the 4-bit ALU operation code consumed by the ALU. It sits between the instruction register (opcode/funct) and the datapath, and closes the loop on the ALU `Zero` flag to form the PC enable for branches.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; held stable by the IR from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU Zero flag.
- `alu_control` out 4: ALU op. Codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- `alu_src_a` out 1: 0 = PC, 1 = regA.
- `alu_src_b` out 2: 00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `iord`, `mem_write`, `ir_write`, `reg_dst`, `mem_to_reg`, `reg_write` out 1 each.
- `pc_en` out 1: `pc_write | (branch & zero)`.
- `illegal_op` out 1: unsupported opcode/funct flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- FETCH: iord=0, src_a=0, src_b=01, ADD, pc_src=00, ir_write=1, pc_write=1 -> DECODE.
- DECODE: src_a=0, src_b=11, ADD. Next by opcode: lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEXEC; j 000010 -> JUMP; other -> FETCH with illegal_op=1 for this cycle.
- MEMADR: src_a=1, src_b=10, ADD -> MEMRD (lw) or MEMWR (sw).
- MEMRD: iord=1 -> MEMWB. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWR: iord=1, mem_write=1 -> FETCH.
- EXECUTE: src_a=1, src_b=00, alu_control from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR; other funct -> ADD with illegal_op=1 -> ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH (write proceeds even on illegal funct).
- BRANCH: src_a=1, src_b=00, SUB, pc_src=01, branch=1 -> FETCH.
- ADDIEXEC: src_a=1, src_b=10, ADD -> ADDIWB. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- All outputs not listed for a state are 0; alu_control defaults to ADD (0010).

## Timing
- State register only; outputs are combinational from state (pc_en also from `zero`).
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Reset: state <= FETCH asynchronously; while rst_n=0 every output is forced 0 (alu_control=0000). First FETCH outputs appear in the first cycle after release.
- Reset mid-instruction: instruction abandoned, no further strobes; restarts at FETCH.
- `zero` is sampled combinationally in BRANCH only; pc_en ignores it in every other state.

## Configuration
- `MC_CTRL_BNE_EN` defined: opcode 000101 (bne) decodes to BRANCH; in BRANCH, pc_en = branch & ~zero for bne, branch & zero for beq (opcode held by IR selects polarity).
- Undefined: 000101 is unsupported -> illegal_op in DECODE, return to FETCH.

## Structure
- `mips_pkg`: state enum, opcode and funct localparams, ALU control code localparams, src_b/pc_src encodings.
- Sub-module `alu_decoder`: combinational funct -> {alu_control, illegal_funct}; instantiated once, selected in EXECUTE only.

## Test plan
- Reset asserted mid-MEMRD -> all outputs 0 immediately; after release, cycle 1 shows ir_write=1, pc_en=1, alu_control=0010.
- lw (opcode 100011) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 with mem_to_reg=1 in cycle 5 only.
- R-type funct 100010 then 100111 -> alu_control 0110 then 1100 in EXECUTE; funct 000000 -> 0010 and illegal_op=1.
- beq with zero=1 -> pc_en=1, pc_src=01 in cycle 3; zero=0 -> pc_en=0; toggling zero in FETCH has no effect on pc_en (stays 1).
- Opcode 111111 -> illegal_op=1 in DECODE, FETCH next cycle, no reg_write/mem_write pulse.
- With `MC_CTRL_BNE_EN`: bne and zero=0 -> pc_en=1; without it -> illegal_op=1, 2-cycle return to FETCH.
